// File: rtl/ecc_pkg.sv
// ecc_pkg: shared constants and enumerations for the GF(2^233) scalar-multiplication datapath.
package ecc_pkg;
    localparam int ECC_N = 233;

    typedef enum logic [1:0] {
        LOADP = 2'b00,
        DBL   = 2'b01,
        ADD   = 2'b10,
        DUMMY = 2'b11
    } pa_op_e;

    typedef enum logic [1:0] {
        KEY_NORMAL  = 2'b00,
        KEY_IS_ZERO = 2'b01,
        KEY_IS_ONE  = 2'b11
    } key_state_e;

    typedef enum logic [3:0] {
        IDLE, LOAD, CHECK, JUDGE, EVAL, FIND, FIND_WAIT,
        CMD, CMD_WAIT, SCAN, SCAN_W1, SCAN_W2, DONE
    } pmul_state_e;
endpackage

// File: rtl/pmul_ctrl_if.sv
// pmul_ctrl_if: point-unit command channel (valid/ready command, single-cycle done pulse).
interface pmul_ctrl_if;
    logic       pa_cmd_valid;
    logic [1:0] pa_cmd_op;
    logic       pa_cmd_ready;
    logic       pa_done;

    modport master(output pa_cmd_valid, pa_cmd_op, input pa_cmd_ready, pa_done);
    modport slave(input pa_cmd_valid, pa_cmd_op, output pa_cmd_ready, pa_done);
endinterface

// File: rtl/pmul_ctrl.sv
// pmul_ctrl: sequences keyscan and point-unit commands for Q = k*P over GF(2^233).
// PMUL_CONST_TIME_EN: follow every DBL with ADD or DUMMY so the command count ignores key weight.
module pmul_ctrl
    import ecc_pkg::*;
#(
    parameter int N     = ECC_N,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [N-1:0]     k_in,
    output logic             busy,
    output logic             done,
    output logic             result_inf,
    output logic             result_is_p,
    output logic [N-1:0]     key_in,
    output logic             key_load,
    output logic             key_check,
    output logic             keyfind_en,
    output logic             keyscan_en,
    input  logic             ki,
    input  logic             key_first_found,
    input  logic [CNT_W-1:0] key_cnt,
    input  logic [1:0]       key_state,
    pmul_ctrl_if.master      pa
);
    pmul_state_e      state, state_n;
    pa_op_e           op, op_n;
    logic [N-1:0]     k_reg, k_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic             inf_n, isp_n, step;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            op          <= LOADP;
            k_reg       <= '0;
            rem         <= '0;
            result_inf  <= 1'b0;
            result_is_p <= 1'b0;
        end else begin
            state       <= state_n;
            op          <= op_n;
            k_reg       <= k_n;
            rem         <= rem_n;
            result_inf  <= inf_n;
            result_is_p <= isp_n;
        end
    end

    always_comb begin
        state_n = state;
        op_n    = op;
        k_n     = k_reg;
        rem_n   = rem;
        inf_n   = result_inf;
        isp_n   = result_is_p;
        step    = 1'b0;
        case (state)
            IDLE: if (start) begin
                k_n     = k_in;
                inf_n   = 1'b0;
                isp_n   = 1'b0;
                state_n = LOAD;
            end
            LOAD:  state_n = CHECK;
            CHECK: state_n = JUDGE;
            JUDGE: state_n = EVAL;
            EVAL: begin
                inf_n   = key_state == KEY_IS_ZERO;
                isp_n   = key_state == KEY_IS_ONE;
                state_n = (inf_n || isp_n) ? DONE : FIND;
            end
            FIND: state_n = FIND_WAIT;
            FIND_WAIT: if (key_first_found) begin
                rem_n   = CNT_W'(N) - key_cnt;
                op_n    = LOADP;
                state_n = CMD;
            end
            CMD: if (pa.pa_cmd_ready) state_n = CMD_WAIT;
            CMD_WAIT: if (pa.pa_done) begin
                if (op == DBL) state_n = SCAN;
                else step = 1'b1;
            end
            SCAN:    state_n = SCAN_W1;
            SCAN_W1: state_n = SCAN_W2;
            SCAN_W2: begin
`ifdef PMUL_CONST_TIME_EN
                op_n    = ki ? ADD : DUMMY;
                state_n = CMD;
`else
                if (ki) begin
                    op_n    = ADD;
                    state_n = CMD;
                end else step = 1'b1;
`endif
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // one bit finished: either stop or double for the next bit; rem is tested before it drops
        if (step) begin
            state_n = rem == '0 ? DONE : CMD;
            rem_n   = rem == '0 ? rem : rem - 1'b1;
            op_n    = DBL;
        end
    end

    assign busy            = state != IDLE;
    assign done            = state == DONE;
    assign key_in          = k_reg;
    assign key_load        = state == LOAD;
    assign key_check       = state == CHECK;
    assign keyfind_en      = state == FIND;
    assign keyscan_en      = state == SCAN;
    assign pa.pa_cmd_valid = state == CMD;
    assign pa.pa_cmd_op    = op;
endmodule

// File: tb/tb_pmul_ctrl.sv
// tb_pmul_ctrl: directed bench for pmul_ctrl with behavioural keyscan and point-unit models.
module tb_pmul_ctrl;
    import ecc_pkg::*;
    localparam int N     = ECC_N;
    localparam int CNT_W = 8;
`ifdef PMUL_CONST_TIME_EN
    localparam int          OPS5   = 5;
    localparam int          OPSBIG = 465;
    localparam int          DUM5   = 1;
    localparam logic [31:0] SEQ5   = 32'h076;
    localparam logic [31:0] SMASK  = 32'h3ff;
`else
    localparam int          OPS5   = 4;
    localparam int          OPSBIG = 234;
    localparam int          DUM5   = 0;
    localparam logic [31:0] SEQ5   = 32'h016;
    localparam logic [31:0] SMASK  = 32'h0ff;
`endif

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             start = 1'b0;
    logic [N-1:0]     k_in = '0;
    logic             busy, done, result_inf, result_is_p;
    logic [N-1:0]     key_in;
    logic             key_load, key_check, keyfind_en, keyscan_en;
    logic             ki, key_first_found;
    logic [CNT_W-1:0] key_cnt;
    logic [1:0]       key_state;

    pmul_ctrl_if pa();

    pmul_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .k_in(k_in),
        .busy(busy), .done(done), .result_inf(result_inf), .result_is_p(result_is_p),
        .key_in(key_in), .key_load(key_load), .key_check(key_check),
        .keyfind_en(keyfind_en), .keyscan_en(keyscan_en), .ki(ki),
        .key_first_found(key_first_found), .key_cnt(key_cnt), .key_state(key_state),
        .pa(pa)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0, n_fail = 0;
    int n_ops = 0, n_dbl = 0, n_add = 0, n_dummy = 0, n_find = 0, n_scan = 0;
    int n_multi = 0, n_hold = 0, n_stall_err = 0;
    int b_ops, b_dbl, b_add, b_dummy, b_find, b_scan, b_hold;
    logic [31:0]  seq = '0;
    logic [1:0]   last_op = '0, prev_op = '0;
    logic [N-1:0] key_m = '0;
    int           pos = 0, fcnt = 0, dcnt = 0, stall_cnt = 0;
    logic         s1 = 1'b0, ks_pipe = 1'b0, prev_wait = 1'b0, stall_req = 1'b0;
    logic         hold, acc;
    int           r_dc, r_nd;
    logic         r_bd, r_ba;

    function automatic int msb(input logic [N-1:0] k);
        msb = 0;
        for (int i = 0; i < N; i++) if (k[i]) msb = i;
    endfunction

    // ready decided at the negedge applies to the next rising edge, so acceptance uses the new value
    assign hold = stall_req && pa.pa_cmd_valid && pa.pa_cmd_op == DBL && stall_cnt < 10;
    assign acc  = pa.pa_cmd_valid && !hold;

    always @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pa.pa_cmd_ready <= 1'b0;
            pa.pa_done      <= 1'b0;
            dcnt            <= 0;
            fcnt            <= 0;
            key_first_found <= 1'b0;
            key_cnt         <= '0;
            key_state       <= '0;
            ki              <= 1'b0;
            ks_pipe         <= 1'b0;
            prev_wait       <= 1'b0;
            stall_cnt       <= 0;
        end else begin
            pa.pa_cmd_ready <= !hold;
            stall_cnt       <= !stall_req ? 0 : stall_cnt + (hold ? 1 : 0);
            if (hold) n_hold <= n_hold + 1;
            if (prev_wait && !(pa.pa_cmd_valid && pa.pa_cmd_op == prev_op)) n_stall_err <= n_stall_err + 1;
            prev_wait <= pa.pa_cmd_valid && !acc;
            prev_op   <= pa.pa_cmd_op;
            if (acc) begin
                n_ops   <= n_ops + 1;
                seq     <= {seq[29:0], pa.pa_cmd_op};
                last_op <= pa.pa_cmd_op;
                if (pa.pa_cmd_op == DBL) n_dbl <= n_dbl + 1;
                if (pa.pa_cmd_op == ADD) n_add <= n_add + 1;
                if (pa.pa_cmd_op == DUMMY) n_dummy <= n_dummy + 1;
                dcnt <= 3;
            end else if (dcnt != 0) dcnt <= dcnt - 1;
            pa.pa_done <= dcnt == 1;
            if (int'(key_load) + int'(key_check) + int'(keyfind_en) + int'(keyscan_en) > 1) n_multi <= n_multi + 1;
            if (key_load) key_m <= key_in;
            if (key_check) key_state <= key_m == '0 ? KEY_IS_ZERO : key_m == N'(1) ? KEY_IS_ONE : KEY_NORMAL;
            if (keyfind_en) begin
                n_find <= n_find + 1;
                pos    <= msb(key_m);
                fcnt   <= N - msb(key_m) + 1;
            end else if (fcnt != 0) fcnt <= fcnt - 1;
            key_first_found <= fcnt == 1;
            key_cnt         <= CNT_W'(N - pos);
            if (keyscan_en) begin
                n_scan <= n_scan + 1;
                pos    <= pos - 1;
                s1     <= key_m[pos-1];
            end
            ks_pipe <= keyscan_en;
            if (ks_pipe) ki <= s1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_ops = n_ops; b_dbl = n_dbl; b_add = n_add; b_dummy = n_dummy;
        b_find = n_find; b_scan = n_scan; b_hold = n_hold;
    endtask

    task automatic run(input logic [N-1:0] k);
        r_dc = -1; r_nd = 0; r_bd = 1'b0; r_ba = 1'b1;
        @(negedge CLK);
        k_in  = k;
        start = 1'b1;
        @(posedge CLK);
        for (int i = 1; i < 8000; i++) begin
            @(negedge CLK);
            start = 1'b0;
            if (done) begin
                r_nd++;
                if (r_dc < 0) begin r_dc = i; r_bd = busy; end
            end
            if (r_dc >= 0 && i == r_dc + 1) r_ba = busy;
            if (r_dc >= 0 && i >= r_dc + 3) break;
        end
    endtask

    initial begin
        logic [N-1:0] kbig;
        repeat (3) @(posedge CLK);
        #1;
        check("rst outs", {busy, done, result_inf, result_is_p, pa.pa_cmd_valid, pa.pa_cmd_op,
                           key_load, key_check, keyfind_en, keyscan_en}, 0);
        check("rst key_in", key_in, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        snap();
        run('0);
        check("k0 done cyc", r_dc, 5);
        check("k0 done cnt", r_nd, 1);
        check("k0 flags", {result_inf, result_is_p}, 2'b10);
        check("k0 cmds", n_ops - b_ops, 0);
        check("k0 find", n_find - b_find, 0);
        check("k0 busy", {r_bd, r_ba}, 2'b10);

        snap();
        run(N'(1));
        check("k1 done cyc", r_dc, 5);
        check("k1 flags", {result_inf, result_is_p}, 2'b01);
        check("k1 cmds", n_ops - b_ops, 0);

        snap();
        run(N'(5));
        check("k5 done cnt", r_nd, 1);
        check("k5 flags", {result_inf, result_is_p}, 2'b00);
        check("k5 ops cnt", n_ops - b_ops, OPS5);
        check("k5 ops seq", seq & SMASK, SEQ5);
        check("k5 dummy", n_dummy - b_dummy, DUM5);
        check("k5 find", n_find - b_find, 1);
        check("k5 scan", n_scan - b_scan, 2);
        check("k5 busy", {r_bd, r_ba}, 2'b10);

        kbig = '0;
        kbig[232] = 1'b1;
        kbig[0] = 1'b1;
        snap();
        run(kbig);
        check("big done cnt", r_nd, 1);
        check("big ops cnt", n_ops - b_ops, OPSBIG);
        check("big dbl", n_dbl - b_dbl, 232);
        check("big add", n_add - b_add, 1);
        check("big last op", last_op, ADD);

        stall_req = 1'b1;
        snap();
        run(N'(5));
        stall_req = 1'b0;
        check("stall hold", n_hold - b_hold, 10);
        check("stall stable", n_stall_err, 0);
        check("stall ops cnt", n_ops - b_ops, OPS5);
        check("stall ops seq", seq & SMASK, SEQ5);

        snap();
        @(negedge CLK);
        k_in  = N'(5);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 0; i < 2000 && n_ops == b_ops; i++) @(negedge CLK);
        check("abort cmd seen", n_ops - b_ops, 1);
        @(negedge CLK);
        check("abort busy pre", busy, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        check("abort outs", {busy, done, result_inf, result_is_p, pa.pa_cmd_valid, pa.pa_cmd_op,
                             key_load, key_check, keyfind_en, keyscan_en}, 0);
        check("abort key_in", key_in, 0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        snap();
        run(N'(5));
        check("rerun done cnt", r_nd, 1);
        check("rerun ops cnt", n_ops - b_ops, OPS5);
        check("rerun ops seq", seq & SMASK, SEQ5);
        check("ctl overlap", n_multi, 0);
`ifndef PMUL_CONST_TIME_EN
        check("no dummy op", n_dummy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pmul_ctrl.md
# pmul_ctrl

- Sequencing controller for 233-bit binary-field ECC scalar multiplication Q = k·P.
- Drives the `keyscan` bit scanner through load, zero/one pre-judge, leading-one search and per-bit scan.
- Issues point commands (load-P, double, add) to the point-arithmetic unit over a valid/ready command channel with a done pulse.
- Sits between the top-level ECC command interface and the `keyscan` / point-unit pair.

## Interface
- `N`, 233, scalar width.
- `CNT_W`, 8, bit-counter width; must satisfy 2^CNT_W > N.
- `CLK` input 1: single clock, rising edge.
- `RST_N` input 1: reset, asynchronous active-low.
- `start` input 1: request one multiplication; sampled only in IDLE.
- `k_in` input N: scalar; captured into `k_reg` when `start` is accepted.
- `busy` output 1: high from start acceptance until the `done` cycle inclusive.
- `done` output 1: one-cycle completion pulse.
- `result_inf` output 1: k = 0, Q is the point at infinity; held until next start.
- `result_is_p` output 1: k = 1, Q = P; held until next start.
- `key_in` output N: driven from `k_reg`.
- `key_load`, `key_check`, `keyfind_en`, `keyscan_en` output 1 each: keyscan controls.
- `ki` input 1: scanned bit from keyscan.
- `key_first_found` input 1: leading one located.
- `key_cnt` input CNT_W: bits consumed by keyscan.
- `key_state` input 2: 00 normal, 01 k = 0, 11 k = 1.
- `pa_cmd_valid` output 1: command valid.
- `pa_cmd_op` output 2: 00 LOADP, 01 DBL, 10 ADD, 11 DUMMY.
- `pa_cmd_ready` input 1: point unit accepts the command.
- `pa_done` input 1: one-cycle pulse when the accepted command completes.

## Operation
- FSM states: IDLE, LOAD, CHECK, JUDGE, EVAL, FIND, FIND_WAIT, CMD, CMD_WAIT, SCAN, SCAN_W1, SCAN_W2, DONE.
- IDLE: on `start`, capture `k_in` into `k_reg`, clear the result flags, set `busy`, go to LOAD.
- LOAD: `key_load` = 1 for one cycle.
- CHECK: `key_check` = 1 for one cycle.
- JUDGE: one wait cycle while keyscan pre-judges.
- EVAL:
  - `key_state` = 01: set `result_inf`, go to DONE.
  - `key_state` = 11: set `result_is_p`, go to DONE.
  - Otherwise go to FIND.
- FIND: `keyfind_en` = 1 for one cycle.
- FIND_WAIT: wait for `key_first_found` = 1, then:
  - load `rem` = N − `key_cnt`;
  - queue op LOADP;
  - go to CMD.
- CMD:
  - Hold `pa_cmd_valid` = 1 and `pa_cmd_op` stable until `pa_cmd_ready`.
  - On handshake, drop valid and go to CMD_WAIT.
- CMD_WAIT: wait for `pa_done`. The next step depends on the op just completed:
  - LOADP or ADD or DUMMY: if `rem` = 0, go to DONE; else decrement `rem`, queue DBL, go to CMD.
  - DBL: go to SCAN.
- SCAN: `keyscan_en` = 1 for one cycle, then SCAN_W1, then SCAN_W2.
- SCAN_W2: `ki` is valid here.
  - `ki` = 1: queue ADD, go to CMD.
  - `ki` = 0: continue as for a completed ADD (check `rem`).
- DONE: `done` = 1 for one cycle, then IDLE; `busy` falls on the following cycle.
- At most one keyscan control is high in any cycle; all four are single-cycle pulses.
- `rem` is CNT_W bits wide and never underflows (it is tested before the decrement).
- `start` while busy is ignored.
- `pa_done` with no accepted command outstanding is ignored.
- `pa_cmd_ready` while valid is low has no effect.

## Timing
- Reset values: all outputs 0, `k_reg` = 0, `rem` = 0, FSM in IDLE.
- Asserting `RST_N` low mid-operation aborts immediately; no `done` is issued. The point unit and keyscan share `RST_N` and are reset in the same event.
- `start` sampled at edge 0 gives LOAD in cycle 1, CHECK in cycle 2, JUDGE in cycle 3, EVAL in cycle 4.
- For k = 0 or k = 1, `done` is asserted in cycle 5.
- FIND_WAIT lasts (N − index of leading one) cycles plus 1.
- Scan latency: 3 cycles from SCAN entry to the `ki` decision.
- Command latency: 1 cycle minimum from entering CMD to handshake, plus point-unit latency.

## Configuration
- `PMUL_CONST_TIME_EN` defined:
  - After every DBL, the controller always issues a second command: ADD when `ki` = 1, DUMMY when `ki` = 0.
  - Command count is 1 + 2·`rem`, independent of the key's Hamming weight.
- `PMUL_CONST_TIME_EN` undefined:
  - The ADD is issued only when `ki` = 1.
  - Op code 11 is never driven.

## Structure
- Shared package `ecc_pkg` holds:
  - the `N` default;
  - the op codes LOADP/DBL/ADD/DUMMY;
  - the key_state codes KEY_NORMAL/KEY_IS_ZERO/KEY_IS_ONE;
  - the FSM state enumeration type.
- No sub-module. `keyscan` and the point unit are siblings of this block and are instantiated at the top level.

## Test plan
- k = 0: `result_inf` = 1 and `done` in cycle 5; zero `pa_cmd_valid` cycles; `keyfind_en` never asserted.
- k = 1: `result_is_p` = 1 and `done` in cycle 5; no point commands.
- k = 5, ready tied high, `pa_done` 3 cycles after each accept: ops LOADP, DBL, DBL, ADD; `keyfind_en` pulsed once; `keyscan_en` pulsed twice.
- k = 2^232 + 1: `key_cnt` = 1 at find; ops LOADP, 232 × DBL, one final ADD; `done` once.
- `pa_cmd_ready` held low 10 cycles during the first DBL: `pa_cmd_valid` and `pa_cmd_op` = 01 stay stable; no extra commands issued.
- `RST_N` pulsed low during CMD_WAIT: all outputs 0 asynchronously; a following k = 5 run with `PMUL_CONST_TIME_EN` gives ops LOADP, DBL, DUMMY, DBL, ADD.
